// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings for the SRAM slave and its helpers:
//   - HTRANS transfer-type codes
//   - HSIZE transfer-size codes (only byte/half/word are supported)
//   - HRESP response codes
//   - data-phase FSM state type
// No ports; imported by ahb_lite_strobe_gen and ahb_lite_sram_slave.
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // ST_IDLE also hosts the completing cycle of a data phase (see active flag
  // in the top); ST_ERR1/ST_ERR2 are the two-cycle ERROR response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_e;

endpackage

// File: rtl/ahb_lite_strobe_gen.sv
// ---------------------------------------------------------------------------
// ahb_lite_strobe_gen
// Turns an AHB transfer size and the two low address bits into a 4-bit
// little-endian byte-lane enable and a flag telling whether the transfer is
// legal (size <= word and address naturally aligned).
// Misaligned low bits are ignored when forming the lanes, so the lanes are
// those of the access aligned down to its size; sizes above word yield all
// four lanes.
// Ports:
//   hsize    in  3  HSIZE of the address phase
//   addr_lo  in  2  HADDR[1:0]
//   strb     out 4  byte-lane enables, bit n = byte lane n
//   align_ok out 1  1 = size supported and address aligned to it
// ---------------------------------------------------------------------------
module ahb_lite_strobe_gen (
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       align_ok
);
  import ahb_lite_pkg::*;

  // Lane decode and alignment legality per transfer size.
  always_comb begin
    strb     = 4'b1111;
    align_ok = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        strb     = 4'b0001 << addr_lo;
        align_ok = 1'b1;
      end
      HSIZE_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        align_ok = ~addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        align_ok = (addr_lo == 2'b00);
      end
      default: begin
        strb     = 4'b1111;
        align_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-Lite slave backed by a DEPTH x 32-bit register-file memory with a
// programmable number of data-phase wait states and full pipelining.
//
// Build option: define AHB_SLV_ERR_CHECK_EN to enable transfer checking
// (size <= word, natural alignment, address inside DEPTH*4 bytes); failing
// transfers get a two-cycle ERROR response and leave memory untouched.
// Without it every transfer is OKAY, addresses wrap modulo DEPTH*4, low
// address bits are aligned down and oversize transfers act as word.
//
// Parameters:
//   DEPTH        number of 32-bit words, power of 2 in 4..256
//   WAIT_STATES  HREADYOUT-low cycles per OKAY data phase, 0..15
// Ports:
//   HCLK       in  1   clock, rising edge
//   HRESETn    in  1   asynchronous active-low reset (clears memory too)
//   HSEL       in  1   slave select
//   HADDR      in  32  byte address
//   HTRANS     in  2   transfer type
//   HWRITE     in  1   1 = write
//   HSIZE      in  3   transfer size
//   HWDATA     in  32  write data (data phase)
//   HREADY     in  1   bus-wide ready
//   HRDATA     out 32  read data, non-zero only on a completing read
//   HREADYOUT  out 1   this slave's ready
//   HRESP      out 1   0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  import ahb_lite_pkg::*;

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  ahb_state_e       state_r, state_nx;
  logic [3:0]       cnt_r, cnt_nx;
  // active_r marks a pending OKAY data phase; together with ST_IDLE it
  // identifies the completing cycle.
  logic             active_r, active_nx;
  logic [AW-1:0]    dp_idx_r;
  logic             dp_write_r;
  logic [3:0]       dp_strb_r;
  logic [31:0]      mem_r [DEPTH];

  logic [3:0]       strb_s;
  logic             align_ok_s;
  logic             legal_s;
  logic             addr_phase_s;
  logic             slot_free_s;
  logic             accept_s;
  logic             complete_s;
  logic             ready_s;
  logic             resp_s;
  ahb_state_e       acc_state_s;
  logic [3:0]       acc_cnt_s;
  logic             acc_active_s;
  logic             unused_s;

  ahb_lite_strobe_gen u_strobe_gen (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .strb     (strb_s),
    .align_ok (align_ok_s)
  );

`ifdef AHB_SLV_ERR_CHECK_EN
  assign legal_s     = align_ok_s & ~(|HADDR[31:AW+2]);
  assign slot_free_s = (state_r == ST_IDLE) | (state_r == ST_ERR2);
  assign unused_s    = 1'b0;
`else
  assign legal_s     = 1'b1;
  assign slot_free_s = (state_r == ST_IDLE);
  assign unused_s    = ^{HADDR[31:AW+2], align_ok_s};
`endif

  // NONSEQ/SEQ carry an address phase; IDLE/BUSY never do.
  always_comb begin
    addr_phase_s = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: addr_phase_s = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  addr_phase_s = 1'b0;
      default:                   addr_phase_s = 1'b0;
    endcase
  end

  // slot_free_s equals HREADYOUT, so this matches the bus accept condition
  // without looping through the output decode.
  assign accept_s   = HSEL & HREADY & addr_phase_s & slot_free_s;
  assign complete_s = (state_r == ST_IDLE) & active_r;

  // Where an accepted address phase leads: wait states, straight to the
  // completing cycle, or the ERROR sequence.
  always_comb begin
    acc_state_s  = ST_IDLE;
    acc_cnt_s    = 4'd0;
    acc_active_s = 1'b0;
    if (legal_s) begin
      acc_active_s = 1'b1;
      if (WS != 4'd0) begin
        acc_state_s = ST_WAIT;
        acc_cnt_s   = WS;
      end else begin
        acc_state_s = ST_IDLE;
        acc_cnt_s   = 4'd0;
      end
    end else begin
`ifdef AHB_SLV_ERR_CHECK_EN
      acc_state_s = ST_ERR1;
`else
      acc_state_s = ST_IDLE;
`endif
      acc_cnt_s    = 4'd0;
      acc_active_s = 1'b0;
    end
  end

  // Next-state and response decode.
  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    active_nx = active_r;
    ready_s   = 1'b1;
    resp_s    = HRESP_OKAY;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx  = acc_state_s;
          cnt_nx    = acc_cnt_s;
          active_nx = acc_active_s;
        end else begin
          state_nx  = ST_IDLE;
          cnt_nx    = 4'd0;
          active_nx = 1'b0;
        end
      end
      ST_WAIT: begin
        ready_s = 1'b0;
        // cnt_r holds the wait cycles still to come including this one.
        if (cnt_r <= 4'd1) begin
          state_nx = ST_IDLE;
          cnt_nx   = 4'd0;
        end else begin
          state_nx = ST_WAIT;
          cnt_nx   = cnt_r - 4'd1;
        end
      end
`ifdef AHB_SLV_ERR_CHECK_EN
      ST_ERR1: begin
        ready_s   = 1'b0;
        resp_s    = HRESP_ERROR;
        state_nx  = ST_ERR2;
        cnt_nx    = 4'd0;
        active_nx = 1'b0;
      end
      ST_ERR2: begin
        resp_s = HRESP_ERROR;
        if (accept_s) begin
          state_nx  = acc_state_s;
          cnt_nx    = acc_cnt_s;
          active_nx = acc_active_s;
        end else begin
          state_nx  = ST_IDLE;
          cnt_nx    = 4'd0;
          active_nx = 1'b0;
        end
      end
`endif
      default: begin
        state_nx  = ST_IDLE;
        cnt_nx    = 4'd0;
        active_nx = 1'b0;
      end
    endcase
  end

  // FSM state, wait counter and data-phase capture registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      active_r   <= 1'b0;
      dp_idx_r   <= '0;
      dp_write_r <= 1'b0;
      dp_strb_r  <= 4'd0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      active_r <= active_nx;
      if (accept_s) begin
        dp_idx_r   <= HADDR[AW+1:2];
        dp_write_r <= HWRITE;
        dp_strb_r  <= strb_s;
      end
    end
  end

  // Memory array; writes land only on the completing cycle so an aborted or
  // erroring transfer never alters contents.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (complete_s && dp_write_r) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_strb_r[b]) begin
          mem_r[dp_idx_r][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA    = (complete_s && !dp_write_r) ? mem_r[dp_idx_r] : 32'd0;
  assign HREADYOUT = ready_s;
  assign HRESP     = resp_s;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
// Two slaves: index 1 has WAIT_STATES=1, index 0 has WAIT_STATES=0, both
// DEPTH=16. Each slave's HREADYOUT is fed back as its HREADY (single-slave
// bus). A directed table, hand-written pipelined/reset sequences and
// randomized transfers are checked against a byte-level memory model.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;

  localparam int DEPTH = 16;
  localparam int BYTES = DEPTH * 4;

  logic        clk;
  logic        rst_n     [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  int checks;
  int failures;

  logic [31:0] mem_m [2][DEPTH];

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_resp;
    int          exp_waits;
  } vec_t;

  vec_t tbl[$];

  ahb_lite_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HWDATA(hwdata[0]), .HREADY(hreadyout[0]), .HRDATA(hrdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  ahb_lite_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HWDATA(hwdata[1]), .HREADY(hreadyout[1]), .HRDATA(hrdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  // Reference rules: legality, and byte-granular write/read on the model.
  function automatic logic m_legal(input logic [2:0] sz, input logic [31:0] ad);
`ifdef AHB_SLV_ERR_CHECK_EN
    if (sz > 3'd2) return 1'b0;
    if ((ad % (32'd1 << sz)) != 32'd0) return 1'b0;
    return (ad < 32'(BYTES));
`else
    return (sz == sz) && (ad == ad);
`endif
  endfunction

  function automatic void m_write(input int d, input logic [2:0] sz, input logic [31:0] ad,
                                  input logic [31:0] wd);
    int unsigned a, s, ba, w, ln;
    a = ad % BYTES;
    s = (sz > 3'd2) ? 2 : int'(sz);
    a = a - (a % (1 << s));
    for (int k = 0; k < (1 << s); k++) begin
      ba = a + k;
      w  = ba / 4;
      ln = ba % 4;
      mem_m[d][w][ln*8 +: 8] = wd[ln*8 +: 8];
    end
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] ad);
    return mem_m[d][(ad % BYTES) / 4];
  endfunction

  task automatic bus_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
    hsize[d] = 3'd2; haddr[d] = 32'd0;
  endtask

  // One non-pipelined transfer; returns the completing-cycle values and a
  // summary of the wait cycles.
  task automatic xfer(input int d, input logic wr, input logic [2:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits, output logic resp,
                      output logic wresp, output logic [31:0] wrd);
    int  n;
    logic done;
    rd = 32'd0; waits = 0; resp = 1'b0; wresp = 1'b0; wrd = 32'd0;
    @(negedge clk);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = ad; hwrite[d] = wr; hsize[d] = sz;
    @(posedge clk); #1;
    bus_idle(d);
    haddr[d] = $urandom;
    hwdata[d] = wd;
    n = 0; done = 1'b0;
    while (!done && n <= 32) begin
      @(negedge clk);
      if (hreadyout[d]) begin
        rd = hrdata[d]; resp = hresp[d]; done = 1'b1;
      end else begin
        waits++; wresp = wresp | hresp[d]; wrd = wrd | hrdata[d]; n++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL xfer_timeout dut=%0d addr=0x%08h actual=no_ready required=ready", d, ad);
    end
    @(posedge clk);
  endtask

  task automatic rnd_xfer(input int d, input int idx);
    logic        wr, lg, resp, wresp;
    logic [2:0]  sz;
    logic [31:0] ad, wd, rd, wrd, exp_rd;
    int          waits, r;
    wr = 1'($urandom_range(0, 1));
    sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'd3;
    r  = $urandom_range(0, 9);
    if (r < 7)      ad = $urandom_range(0, BYTES - 1);
    else if (r < 9) ad = $urandom_range(BYTES, 4 * BYTES);
    else            ad = $urandom;
    wd = $urandom;
    lg = m_legal(sz, ad);
    exp_rd = (lg && !wr) ? m_read(d, ad) : 32'd0;
    xfer(d, wr, sz, ad, wd, rd, waits, resp, wresp, wrd);
    chk($sformatf("rnd%0d_%0d_rdata", d, idx), rd, exp_rd);
    chk($sformatf("rnd%0d_%0d_resp", d, idx), 32'(resp), 32'(!lg));
    chk($sformatf("rnd%0d_%0d_waits", d, idx), 32'(waits), 32'(lg ? ws_of(d) : 1));
    chk($sformatf("rnd%0d_%0d_wresp", d, idx), 32'(wresp), 32'(!lg));
    chk($sformatf("rnd%0d_%0d_wrdata", d, idx), wrd, 32'd0);
    if (lg && wr) m_write(d, sz, ad, wd);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk($sformatf("rnd%0d_%0d_gap_ready", d, idx), 32'(hreadyout[d]), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd, wrd;
    logic        resp, wresp;
    int          waits;

    checks = 0; failures = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hwdata[d] = 32'd0;
      bus_idle(d);
      for (int w = 0; w < DEPTH; w++) mem_m[d][w] = 32'd0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(hreadyout[d]), 32'd1);
      chk($sformatf("rst%0d_resp", d), 32'(hresp[d]), 32'd0);
      chk($sformatf("rst%0d_rdata", d), hrdata[d], 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Directed table on the one-wait-state slave.
    tbl.push_back('{1'b1, 3'd2, 32'h04, 32'hDEADBEEF, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0, 1});
    tbl.push_back('{1'b1, 3'd2, 32'h0C, 32'h0,        32'h0,        1'b0, 1});
    tbl.push_back('{1'b1, 3'd0, 32'h0D, 32'hAAAAAAAA, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h0C, 32'h0,        32'h0000AA00, 1'b0, 1});
    tbl.push_back('{1'b1, 3'd1, 32'h0E, 32'h55667788, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h0C, 32'h0,        32'h5566AA00, 1'b0, 1});
    tbl.push_back('{1'b1, 3'd0, 32'h0C, 32'h11223344, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h0C, 32'h0,        32'h5566AA44, 1'b0, 1});
`ifdef AHB_SLV_ERR_CHECK_EN
    tbl.push_back('{1'b0, 3'd2, 32'h40, 32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{1'b1, 3'd1, 32'h01, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h00, 32'h0,        32'h0,        1'b0, 1});
    tbl.push_back('{1'b1, 3'd2, 32'h06, 32'h12345678, 32'h0,        1'b1, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h04, 32'h0,        32'hDEADBEEF, 1'b0, 1});
    tbl.push_back('{1'b1, 3'd3, 32'h08, 32'h87654321, 32'h0,        1'b1, 1});
`else
    tbl.push_back('{1'b1, 3'd2, 32'h44, 32'h00000055, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h04, 32'h0,        32'h00000055, 1'b0, 1});
    tbl.push_back('{1'b1, 3'd1, 32'h01, 32'h0000BBCC, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h00, 32'h0,        32'h0000BBCC, 1'b0, 1});
    tbl.push_back('{1'b1, 3'd3, 32'h08, 32'h87654321, 32'h0,        1'b0, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h08, 32'h0,        32'h87654321, 1'b0, 1});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(1, tbl[i].wr, tbl[i].sz, tbl[i].ad, tbl[i].wd, rd, waits, resp, wresp, wrd);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_resp", i), 32'(resp), 32'(tbl[i].exp_resp));
      chk($sformatf("tbl%0d_waits", i), 32'(waits), 32'(tbl[i].exp_waits));
      chk($sformatf("tbl%0d_wait_resp", i), 32'(wresp), 32'(tbl[i].exp_resp));
      @(negedge clk);
      chk($sformatf("tbl%0d_after_ready", i), 32'(hreadyout[1]), 32'd1);
      chk($sformatf("tbl%0d_after_resp", i), 32'(hresp[1]), 32'd0);
      if (tbl[i].wr && !tbl[i].exp_resp) m_write(1, tbl[i].sz, tbl[i].ad, tbl[i].wd);
    end

    // IDLE/BUSY with HSEL=1 and NONSEQ with HSEL=0 must not start a transfer.
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b01; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    haddr[1] = 32'h04; hwdata[1] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("busy_ready", 32'(hreadyout[1]), 32'd1);
    chk("busy_resp", 32'(hresp[1]), 32'd0);
    hsel[1] = 1'b0; htrans[1] = 2'b10;
    @(negedge clk);
    chk("desel_ready", 32'(hreadyout[1]), 32'd1);
    hsel[1] = 1'b1; htrans[1] = 2'b00;
    @(negedge clk);
    chk("idle_ready", 32'(hreadyout[1]), 32'd1);
    bus_idle(1);
    xfer(1, 1'b0, 3'd2, 32'h04, 32'h0, rd, waits, resp, wresp, wrd);
    chk("nodp_mem_intact", rd, m_read(1, 32'h04));

    // Back-to-back write then read with one wait state.
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h20; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    hwrite[1] = 1'b0; hwdata[1] = 32'h0BADF00D;
    @(negedge clk);
    chk("b2b1_w_wait", 32'(hreadyout[1]), 32'd0);
    @(negedge clk);
    chk("b2b1_w_done", 32'(hreadyout[1]), 32'd1);
    @(posedge clk); #1;
    bus_idle(1);
    @(negedge clk);
    chk("b2b1_r_wait", 32'(hreadyout[1]), 32'd0);
    @(negedge clk);
    chk("b2b1_r_done", 32'(hreadyout[1]), 32'd1);
    chk("b2b1_r_data", hrdata[1], 32'h0BADF00D);
    chk("b2b1_r_resp", 32'(hresp[1]), 32'd0);
    m_write(1, 3'd2, 32'h20, 32'h0BADF00D);

    // Zero-wait slave: NONSEQ write then immediate read, no bubble.
    @(negedge clk);
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h08; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    @(posedge clk); #1;
    hwrite[0] = 1'b0; hwdata[0] = 32'h11223344;
    @(negedge clk);
    chk("b2b0_w_nowait", 32'(hreadyout[0]), 32'd1);
    chk("b2b0_w_rdata0", hrdata[0], 32'd0);
    @(posedge clk); #1;
    bus_idle(0);
    @(negedge clk);
    chk("b2b0_r_nowait", 32'(hreadyout[0]), 32'd1);
    chk("b2b0_r_data", hrdata[0], 32'h11223344);
    chk("b2b0_r_resp", 32'(hresp[0]), 32'd0);
    m_write(0, 3'd2, 32'h08, 32'h11223344);

    for (int i = 0; i < 60; i++) rnd_xfer(1, i);
    for (int i = 0; i < 40; i++) rnd_xfer(0, i);

    // Reset pulse during the wait state of a write aborts it.
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h00; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    bus_idle(1);
    hwdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstw_in_wait", 32'(hreadyout[1]), 32'd0);
    #1 rst_n[1] = 1'b0;
    #1;
    chk("rstw_ready", 32'(hreadyout[1]), 32'd1);
    chk("rstw_resp", 32'(hresp[1]), 32'd0);
    chk("rstw_rdata", hrdata[1], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int w = 0; w < DEPTH; w++) mem_m[1][w] = 32'd0;
    xfer(1, 1'b0, 3'd2, 32'h00, 32'h0, rd, waits, resp, wresp, wrd);
    chk("rstw_read0", rd, 32'd0);
    chk("rstw_read0_waits", 32'(waits), 32'd1);
    xfer(1, 1'b0, 3'd2, 32'h04, 32'h0, rd, waits, resp, wresp, wrd);
    chk("rstw_read4_cleared", rd, m_read(1, 32'h04));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit words (power of 2, 4..256).
REQ-002 SHALL have parameter WAIT_STATES, default 1, data-phase wait cycles per OKAY transfer (0..15).
REQ-003 HCLK  in  1  sole clock; all state on rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 HSEL  in  1  slave select from decoder.
REQ-006 HADDR  in  32  byte address.
REQ-007 HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 HWRITE  in  1  1=write.
REQ-009 HSIZE  in  3  0=byte, 1=half, 2=word; others illegal.
REQ-010 HWDATA  in  32  write data, data phase.
REQ-011 HREADY  in  1  bus-wide ready from the response multiplexor.
REQ-012 HRDATA  out  32  read data.
REQ-013 HREADYOUT  out  1  this slave's ready.
REQ-014 HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-015 SHALL accept an address phase only when HSEL=1, HREADY=1, HTRANS[1]=1; it captures HADDR, HWRITE, HSIZE into data-phase registers.
REQ-016 IDLE/BUSY or HSEL=0 with HREADY=1 SHALL produce no data phase; outputs stay HREADYOUT=1, HRESP=0.
REQ-017 FSM states IDLE, WAIT, ERR1, ERR2; legal accept -> WAIT if WAIT_STATES>0, else completes in the next cycle from IDLE; illegal accept -> ERR1.
REQ-018 WAIT: HREADYOUT=0, HRESP=0 for exactly WAIT_STATES cycles (down-counter); final data-phase cycle HREADYOUT=1.
REQ-019 ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; ERR2 -> IDLE, or directly to a new data phase if a transfer is accepted that cycle.
REQ-020 Write SHALL commit HWDATA to memory only on the completing (HREADYOUT=1, OKAY) cycle, byte lanes per HSIZE and HADDR[1:0] (little-endian).
REQ-021 Read completing cycle: HRDATA = mem[word index] (combinational from memory); all other cycles HRDATA=0.
REQ-022 Back-to-back pipelining SHALL be supported: a new address phase accepted in a completing cycle starts its data phase next cycle with no bubble.
REQ-023 Write then read of same address back-to-back SHALL return the newly written data.
REQ-024 Word index = HADDR[log2(DEPTH)+1:2]; upper bits used only per REQ-032.

Reset
REQ-025 HRESETn low SHALL force within the same cycle: state IDLE, wait counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, all memory words 0.
REQ-026 Reset mid-transfer SHALL abort it; no pending write commits.
REQ-027 First accept possible on the first HCLK edge after HRESETn deasserts.

Configuration
REQ-028 Macro AHB_SLV_ERR_CHECK_EN SHALL select error checking.
REQ-029 Defined: legal = HSIZE<=2, address aligned to HSIZE, HADDR < DEPTH*4; illegal -> ERROR per REQ-019, memory untouched.
REQ-030 Undefined: every transfer OKAY; address wraps modulo DEPTH*4; misaligned low bits ignored (aligned down); HSIZE>2 treated as word.
REQ-031 ERR1/ERR2 logic SHALL not be synthesised when undefined.
REQ-032 Out-of-range check uses HADDR[31:log2(DEPTH)+2] != 0.

Structure
REQ-033 Shared package ahb_lite_pkg: HTRANS codes, HSIZE codes, HRESP codes, FSM state typedef.
REQ-034 One sub-module ahb_lite_strobe_gen: HSIZE + HADDR[1:0] -> 4-bit byte-lane enable and alignment-legal flag.

Verification
REQ-035 WAIT_STATES=1: write word 0xDEADBEEF @0x04, read @0x04 -> one HREADYOUT=0 cycle each, HRDATA=0xDEADBEEF, HRESP=0.
REQ-036 WAIT_STATES=0: NONSEQ write 0x11223344 @0x08 then immediate read @0x08 -> no wait, read returns 0x11223344.
REQ-037 Byte write 0xAA @0x0D onto word 0 @0x0C -> read @0x0C = 0x0000AA00.
REQ-038 With AHB_SLV_ERR_CHECK_EN: read @0x40 (DEPTH=16) -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (1,1), then IDLE; half write @0x01 -> same, memory unchanged.
REQ-039 Without macro: write 0x55 word @0x44 -> read @0x04 = 0x00000055, HRESP=0.
REQ-040 HRESETn pulsed during WAIT of write 0xCAFEF00D @0x00 -> outputs at reset values, read @0x00 returns 0.
